// File: rtl/seg_scan_capture.sv
// Samples a multiplexed 4-digit 7-segment display bus back into BCD.
// Define SEG_SCAN_CAPTURE_DP_EN to also capture the decimal points.
module seg_scan_capture #(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        dp,
  input  logic        clr_err,
  output logic [15:0] digit,
  output logic [3:0]  blank,
  output logic [3:0]  dp_out,
  output logic        frame_valid,
  output logic        err_seg,
  output logic        err_an,
  output logic        stale
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {
    WAIT,
    HOLD
  } state_t;

  logic [6:0] seg_s1;
  logic [6:0] seg_s2;
  logic [3:0] an_s1;
  logic [3:0] an_s2;
  logic       dp_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      an_s1  <= '0;
      an_s2  <= '0;
    end else begin
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      an_s1  <= an;
      an_s2  <= an_s1;
    end
  end

`ifdef SEG_SCAN_CAPTURE_DP_EN
  localparam int VW = 12;

  logic dp_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_s1 <= 1'b0;
      dp_s2 <= 1'b0;
    end else begin
      dp_s1 <= dp;
      dp_s2 <= dp_s1;
    end
  end

  logic [VW-1:0] vec;
  assign vec = {an_s2, seg_s2, dp_s2};
`else
  localparam int VW = 11;

  logic dp_unused;
  assign dp_unused = dp;
  assign dp_s2     = 1'b1;

  logic [VW-1:0] vec;
  assign vec = {an_s2, seg_s2};
`endif

  state_t        state;
  logic [SW-1:0] stab_cnt;
  logic [VW-1:0] vec_q;
  logic          changed;
  logic          sample;

  assign changed = (vec != vec_q);
  assign sample  = (state == WAIT) && !changed &&
                   (stab_cnt == SW'(SETTLE_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT;
      stab_cnt <= '0;
      vec_q    <= '0;
    end else begin
      vec_q <= vec;
      if (changed) begin
        state    <= WAIT;
        stab_cnt <= '0;
      end else if (state == WAIT) begin
        if (sample) begin
          state <= HOLD;
        end else begin
          stab_cnt <= stab_cnt + 1'b1;
        end
      end
    end
  end

  logic       one_hot;
  logic [1:0] pos;

  always_comb begin
    one_hot = 1'b1;
    pos     = 2'd0;
    case (an_s2)
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: one_hot = 1'b0;
    endcase
  end

  logic [3:0] dec_val;
  logic       dec_ok;
  logic       dec_blank;

  always_comb begin
    dec_val   = 4'h0;
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    case (seg_s2)
      7'h40: dec_val = 4'd0;
      7'h79: dec_val = 4'd1;
      7'h24: dec_val = 4'd2;
      7'h30: dec_val = 4'd3;
      7'h19: dec_val = 4'd4;
      7'h12: dec_val = 4'd5;
      7'h02: dec_val = 4'd6;
      7'h78: dec_val = 4'd7;
      7'h00: dec_val = 4'd8;
      7'h10: dec_val = 4'd9;
      7'h7F: dec_blank = 1'b1;
      default: begin
        dec_val = 4'hF;
        dec_ok  = 1'b0;
      end
    endcase
  end

  logic       store;
  logic       an_bad;
  logic       seg_bad;
  logic [3:0] pos_mask;

  assign store    = sample && one_hot;
  assign an_bad   = sample && !one_hot && (an_s2 != 4'hF);
  assign seg_bad  = store && !dec_ok;
  assign pos_mask = store ? ~an_s2 : 4'h0;

  logic [15:0]   sh_digit;
  logic [3:0]    sh_blank;
  logic [3:0]    seen;
  logic          frame_go;
  logic [TW-1:0] cap_cnt;

  assign frame_go = (seen == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_digit    <= '0;
      sh_blank    <= '0;
      seen        <= '0;
      digit       <= '0;
      blank       <= '0;
      frame_valid <= 1'b0;
      err_seg     <= 1'b0;
      err_an      <= 1'b0;
      stale       <= 1'b0;
      cap_cnt     <= '0;
    end else begin
      frame_valid <= frame_go;
      if (frame_go) begin
        digit <= sh_digit;
        blank <= sh_blank;
      end
      seen <= (frame_go ? 4'h0 : seen) | pos_mask;
      if (store) begin
        sh_digit[{pos, 2'b00} +: 4] <= dec_val;
        sh_blank[pos]               <= dec_blank;
      end
      // a fresh error outranks a same-cycle clear
      err_seg <= (err_seg & ~clr_err) | seg_bad;
      err_an  <= (err_an & ~clr_err) | an_bad;
      if (store) begin
        cap_cnt <= '0;
      end else if (cap_cnt != TW'(TIMEOUT_CYC)) begin
        cap_cnt <= cap_cnt + 1'b1;
      end
      if (frame_go) begin
        stale <= 1'b0;
      end else if (!store &&
                   cap_cnt == TW'(TIMEOUT_CYC - 1)) begin
        stale <= 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_CAPTURE_DP_EN
  logic [3:0] sh_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_dp  <= '0;
      dp_out <= '0;
    end else begin
      if (store) begin
        sh_dp[pos] <= ~dp_s2;
      end
      if (frame_go) begin
        dp_out <= sh_dp;
      end
    end
  end
`else
  assign dp_out = 4'h0;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Randomized bench for seg_scan_capture against a table-driven frame model.
// Runs with SETTLE_CYC=16 and TIMEOUT_CYC=1000.
module tb_seg_scan_capture;

  localparam int SETTLE = 16;
  localparam int TMO    = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an = 4'hF;
  logic        dp = 1'b1;
  logic        clr_err = 1'b0;
  logic [15:0] digit;
  logic [3:0]  blank;
  logic [3:0]  dp_out;
  logic        frame_valid;
  logic        err_seg;
  logic        err_an;
  logic        stale;

  int errors = 0;
  int checks = 0;
  int fv_cnt = 0;
  int cyc = 0;
  int last_fv = 0;

  seg_scan_capture #(
    .SETTLE_CYC (SETTLE),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .clr_err    (clr_err),
    .digit      (digit),
    .blank      (blank),
    .dp_out     (dp_out),
    .frame_valid(frame_valid),
    .err_seg    (err_seg),
    .err_an     (err_an),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (frame_valid) begin
      fv_cnt  <= fv_cnt + 1;
      last_fv <= cyc;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  localparam logic [6:0] TBL [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // {bad, blank, value}
  function automatic logic [5:0] ref_decode(input logic [6:0] s);
    if (s == 7'h7F) return 6'b01_0000;
    for (int k = 0; k < 10; k++)
      if (TBL[k] == s) return {2'b00, 4'(k)};
    return 6'b10_1111;
  endfunction

  function automatic logic [6:0] pick_seg(input int r);
    logic [6:0] s;
    if (r < 10) return TBL[r];
    if (r == 10) return 7'h7F;
    s = 7'($urandom_range(0, 127));
    while (ref_decode(s)[5] == 1'b0)
      s = 7'($urandom_range(0, 127));
    return s;
  endfunction

  task automatic model_frame(
    input  logic [27:0] segs,
    input  logic [3:0]  dps,
    output logic [15:0] d,
    output logic [3:0]  b,
    output logic [3:0]  p,
    output logic        bad
  );
    logic [5:0] r;
    bad = 1'b0;
    d   = '0;
    b   = '0;
    for (int i = 0; i < 4; i++) begin
      r = ref_decode(segs[7*i +: 7]);
      d[4*i +: 4] = r[3:0];
      b[i] = r[4];
      bad = bad | r[5];
    end
`ifdef SEG_SCAN_CAPTURE_DP_EN
    p = ~dps;
`else
    p = 4'h0;
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s,
                       input logic d, input int n);
    an  = a;
    seg = s;
    dp  = d;
    tick(n);
  endtask

  task automatic drive_pos(input int i, input logic [6:0] s,
                           input logic d, input int n);
    logic [3:0] a;
    a = 4'b0001 << i;
    drive(~a, s, d, n);
  endtask

  task automatic scan(input logic [27:0] segs, input logic [3:0] dps,
                      input int h);
    for (int i = 3; i >= 0; i--)
      drive_pos(i, segs[7*i +: 7], dps[i], h);
    drive(4'hF, 7'h7F, 1'b1, 10);
  endtask

  task automatic pulse_clr;
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({digit, blank, dp_out, frame_valid,
         err_seg, err_an, stale} !== 29'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {digit, blank, dp_out, frame_valid,
                err_seg, err_an, stale});
    end
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_clock_1234;
    int f0;
    f0 = fv_cnt;
    scan({7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 100);
    checks++;
    if (fv_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL c1234_frames: got %0d want 1", fv_cnt - f0);
    end
    checks++;
    if (digit !== 16'h1234) begin
      errors++;
      $display("FAIL c1234_digit: got %h want 1234", digit);
    end
    checks++;
    if (blank !== 4'h0) begin
      errors++;
      $display("FAIL c1234_blank: got %b want 0000", blank);
    end
    checks++;
    if ({err_seg, err_an} !== 2'b00) begin
      errors++;
      $display("FAIL c1234_err: got %b want 00", {err_seg, err_an});
    end
    checks++;
    if (dp_out !== 4'h0) begin
      errors++;
      $display("FAIL c1234_dp: got %b want 0000", dp_out);
    end
  endtask

  task automatic test_blank;
    int f0;
    f0 = fv_cnt;
    scan({7'h79, 7'h24, 7'h7F, 7'h19}, 4'hF, 40);
    checks++;
    if (fv_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL blank_frames: got %0d want 1", fv_cnt - f0);
    end
    checks++;
    if (digit !== 16'h1204) begin
      errors++;
      $display("FAIL blank_digit: got %h want 1204", digit);
    end
    checks++;
    if (blank !== 4'b0010) begin
      errors++;
      $display("FAIL blank_mask: got %b want 0010", blank);
    end
    checks++;
    if (err_seg !== 1'b0) begin
      errors++;
      $display("FAIL blank_err_seg: got %b want 0", err_seg);
    end
  endtask

  task automatic test_glitch;
    int f0;
    f0 = fv_cnt;
    drive_pos(3, 7'h79, 1'b1, 40);
    drive_pos(2, 7'h24, 1'b1, 40);
    drive_pos(1, 7'h30, 1'b1, 30);
    drive_pos(1, 7'h7F, 1'b1, 5);
    drive_pos(1, 7'h30, 1'b1, 3);
    drive_pos(0, 7'h19, 1'b1, 40);
    drive(4'hF, 7'h7F, 1'b1, 10);
    checks++;
    if (fv_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL glitch_frames: got %0d want 1", fv_cnt - f0);
    end
    checks++;
    if ({digit, blank} !== {16'h1234, 4'h0}) begin
      errors++;
      $display("FAIL glitch_digit: got %h/%b want 1234/0000",
               digit, blank);
    end
  endtask

  task automatic test_multi_anode;
    int f0;
    f0 = fv_cnt;
    drive(4'b0011, 7'h79, 1'b1, 50);
    drive(4'hF, 7'h7F, 1'b1, 30);
    checks++;
    if (err_an !== 1'b1) begin
      errors++;
      $display("FAIL multi_err_an: got %b want 1", err_an);
    end
    checks++;
    if (fv_cnt - f0 !== 0) begin
      errors++;
      $display("FAIL multi_frames: got %0d want 0", fv_cnt - f0);
    end
    pulse_clr();
    checks++;
    if (err_an !== 1'b0) begin
      errors++;
      $display("FAIL multi_clr: got %b want 0", err_an);
    end
  endtask

  task automatic test_random;
    logic [27:0] segs;
    logic [3:0]  dps;
    logic [15:0] ed;
    logic [3:0]  eb;
    logic [3:0]  ep;
    logic        ebad;
    int          f0;
    int          h;
    for (int n = 0; n < 8; n++) begin
      pulse_clr();
      for (int i = 0; i < 4; i++)
        segs[7*i +: 7] = pick_seg($urandom_range(0, 11));
      dps = 4'($urandom_range(0, 15));
      h   = $urandom_range(30, 60);
      model_frame(segs, dps, ed, eb, ep, ebad);
      f0 = fv_cnt;
      // decoy on the first position must be overwritten
      if ($urandom_range(0, 1) == 1)
        drive_pos(3, TBL[$urandom_range(0, 9)], 1'b0, h);
      scan(segs, dps, h);
      checks++;
      if (fv_cnt - f0 !== 1) begin
        errors++;
        $display("FAIL rnd%0d_frames: got %0d want 1", n, fv_cnt - f0);
      end
      checks++;
      if (digit !== ed) begin
        errors++;
        $display("FAIL rnd%0d_digit: got %h want %h", n, digit, ed);
      end
      checks++;
      if (blank !== eb) begin
        errors++;
        $display("FAIL rnd%0d_blank: got %b want %b", n, blank, eb);
      end
      checks++;
      if (dp_out !== ep) begin
        errors++;
        $display("FAIL rnd%0d_dp: got %b want %b", n, dp_out, ep);
      end
      checks++;
      if ({err_seg, err_an} !== {ebad, 1'b0}) begin
        errors++;
        $display("FAIL rnd%0d_err: got %b want %b",
                 n, {err_seg, err_an}, {ebad, 1'b0});
      end
    end
    pulse_clr();
  endtask

  task automatic test_stale;
    int k;
    int d;
    int f0;
    scan({7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 40);
    k = 0;
    while (stale !== 1'b1 && k < 2000) begin
      tick(1);
      k++;
    end
    d = cyc - last_fv;
    checks++;
    if (stale !== 1'b1 || d < TMO - 5 || d > TMO + 5) begin
      errors++;
      $display("FAIL stale_rise: got stale=%b after %0d cycles want 1 near %0d",
               stale, d, TMO);
    end
    tick(50);
    checks++;
    if (stale !== 1'b1) begin
      errors++;
      $display("FAIL stale_hold: got %b want 1", stale);
    end
    f0 = fv_cnt;
    scan({7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 40);
    checks++;
    if (fv_cnt - f0 !== 1 || stale !== 1'b0) begin
      errors++;
      $display("FAIL stale_clear: got frames=%0d stale=%b want 1/0",
               fv_cnt - f0, stale);
    end
  endtask

  task automatic test_reset_midframe;
    int f0;
    drive_pos(3, 7'h79, 1'b1, 40);
    drive_pos(2, 7'h24, 1'b1, 40);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({digit, blank, dp_out, frame_valid,
         err_seg, err_an, stale} !== 29'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %h want 0",
               {digit, blank, dp_out, frame_valid,
                err_seg, err_an, stale});
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    f0 = fv_cnt;
    drive_pos(1, 7'h30, 1'b1, 40);
    drive_pos(0, 7'h19, 1'b1, 40);
    drive(4'hF, 7'h7F, 1'b1, 30);
    checks++;
    if (fv_cnt - f0 !== 0) begin
      errors++;
      $display("FAIL rst_mid_frames: got %0d want 0", fv_cnt - f0);
    end
    checks++;
    if (digit !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_digit: got %h want 0000", digit);
    end
  endtask

  initial begin
    test_reset();
    test_clock_1234();
    test_blank();
    test_glitch();
    test_multi_anode();
    test_random();
    test_stale();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
